// File: rtl/kernel_result_collector.sv
// Result collector behind the 2x2 systolic kernel: tracks sample validity through
// the kernel latency, sums groups of four valid results and queues the sums.
module kernel_result_collector #(
  parameter int dataSize = 8,
  parameter int LATENCY  = 2,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [2*dataSize+4:0]       result,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [2*dataSize+6:0]       out_data,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow
);
  localparam int RW = 2*dataSize + 5;
  localparam int OW = RW + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [LATENCY:0]   tag_ext;
  logic [OW-1:0]      acc_q, acc_d, sum;
  logic [1:0]         grp_q, grp_d;
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               valid_q, full_q, ovf_q, ovf_d;
  logic [OW-1:0]      mem_q [DEPTH];
  logic               capture, push, pop, wr, drop;

  // tag[LATENCY-1] marks the sample whose result is on the bus right now
  assign tag_ext = {tag_q, in_valid};
  assign capture = en && tag_q[LATENCY-1];
  assign sum     = acc_q + OW'(result);
  assign push    = capture && (grp_q == 2'd3);
  assign pop     = valid_q && out_ready;
  assign wr      = push && (!full_q || pop);
  assign drop    = push && full_q && !pop;

  always_comb begin
    tag_d   = tag_q;
    acc_d   = acc_q;
    grp_d   = grp_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      tag_d   = '0;
      acc_d   = '0;
      grp_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (en) tag_d = tag_ext[LATENCY-1:0];
      if (capture) begin
        if (grp_q == 2'd3) begin
          acc_d = '0;
          grp_d = '0;
        end else begin
          acc_d = sum;
          grp_d = grp_q + 2'd1;
        end
      end
      if (wr)  wptr_d = wptr_q + AW'(1);
      if (pop) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(wr) - CW'(pop);
      ovf_d   = ovf_q | drop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q   <= '0;
      acc_q   <= '0;
      grp_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      grp_q   <= grp_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == CW'(DEPTH));
      ovf_q   <= ovf_d;
      if (!clr && wr) mem_q[wptr_q] <= sum;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? mem_q[rptr_q] : '0;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/kernel_result_collector.md
# kernel_result_collector

Downstream stage of the 2x2 systolic kernel. It consumes the kernel's combined `result` word and identifies which cycles carry real data by tracking input validity through the kernel pipeline. It sums groups of ACC_LEN = 4 valid results and buffers the sums in a small FIFO. The FIFO drains through a valid/ready handshake to the next stage (write-back / output bus).

## Interface
- `dataSize`, default 8: kernel operand width. Kernel result width RW = 2*dataSize+5.
- `LATENCY`, default 2: number of enabled kernel cycles from input sample to its `result`. Must be ≥ 1.
- `DEPTH`, default 4: number of FIFO entries, power of two.
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous flush. Clears the tag pipe, accumulator, group counter, FIFO and `overflow`.
- `en`  in  1  the same enable driven into the kernel. The tag pipe advances only when `en`=1.
- `in_valid`  in  1  the sample presented to the kernel this cycle is real data.
- `result`  in  RW  kernel result bus, unsigned.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_valid`  out  1  FIFO not empty.
- `out_data`  out  RW+2  head FIFO entry: sum of 4 results.
- `full`  out  1  FIFO holds DEPTH entries. Upstream should drop `en` while this is high.
- `count`  out  clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: at least one group sum was dropped.

## Operation
- Tag pipe: LATENCY-bit shift register. When `en`=1, tag[0] ← `in_valid` and tag[i] ← tag[i-1]. When `en`=0, it holds.
- A result is captured in a cycle when `en`=1 and tag[LATENCY-1]=1. That tag is the one for the sample whose result is on `result` now.
- Accumulator (RW+2 bits, unsigned) and 2-bit group counter `grp`, both starting at 0.
- On capture with `grp` < 3: acc ← acc + `result`, grp ← grp + 1.
- On capture with `grp` = 3: the value acc + `result` is pushed to the FIFO. Then acc ← 0 and grp ← 0.
- Width rule: 4·(2^RW − 1) < 2^(RW+2), so the sum is exact. No saturation and no truncation.
- FIFO: circular buffer with read/write pointers that wrap modulo DEPTH, plus an occupancy count.
- Pop occurs when `out_valid` && `out_ready`.
- Push when not full: the entry is written.
- Push when full with no pop in the same cycle: the sum is discarded and `overflow` ← 1. The accumulator still clears.
- Push and pop in the same cycle while full: both succeed and `count` stays at DEPTH. No overflow.
- Push and pop in the same cycle while empty: not possible, because `out_valid`=0. The push lands and `count` becomes 1.
- `overflow` clears only on `rst` or `clr`.
- `clr` has priority over capture, push and pop in the same cycle. A group in progress is lost without flagging.
- `out_data` equals the head entry whenever `out_valid`=1. It is don't-care otherwise; drive 0 for determinism.

## Timing
- Reset values (async on `rst`=0): tags 0, acc 0, grp 0, pointers 0, `count` 0, `out_valid` 0, `out_data` 0, `full` 0, `overflow` 0.
- Reset asserted mid-group or mid-drain discards everything immediately.
- Capture is sampled on the same edge where `result` is valid. No extra input register.
- Fourth capture at edge N: `out_valid`=1 and `out_data` = sum after edge N, if the FIFO was empty.
- End-to-end: in_valid of the 4th sample to `out_valid` takes LATENCY enabled edges + 1 edge, counting the capture edge.
- `out_valid`, `full` and `count` are registered. None depends combinationally on `out_ready`.
- Throughput: at most one push per 4 captures and at most one pop per cycle, so a drain with `out_ready` held high never fills the FIFO.
- While `en`=0, `result` is ignored, even if tag[LATENCY-1]=1.

## Test plan
- Basic group: LATENCY=2, `en`=1, in_valid held for 4 samples, `result` 10,20,30,40 on the capture cycles, `out_ready`=1. Expect one `out_valid` pulse with `out_data`=100 and `count` back at 0.
- Latency/stall gating: in_valid=1 for 1 cycle, then `en`=0 for 3 cycles with `result`=999. Then `en`=1, and the next enabled cycle after the tag reaches the end carries `result`=5. Expect 999 never accumulated and only 5 captured (grp=1).
- Max width: 4 captures of `result` = 2^21−1 (dataSize=8). Expect `out_data` = 8388604 with no wrap.
- Full/overflow: `out_ready`=0, 5 complete groups (sums 4,8,12,16,20). Expect `count`=4, `full`=1, `overflow`=1. Draining yields 4,8,12,16, and `overflow` stays 1 until `clr`.
- Simultaneous push/pop at full: FIFO full, `out_ready`=1 on the cycle a 5th group completes. Expect `count` to stay at 4, `overflow`=0, and the new sum to arrive last in order.
- Reset mid-group: 2 captures (7, 9), then `rst` low for 1 cycle, then 4 captures of 1. Expect `out_data`=4 (not 20). Repeat the sequence with `clr` and expect the same result.
